// File: rtl/tag_nios_system_sysid_arbiter.sv
// Round-robin arbiter sharing the read-only sysid slave between two Avalon-MM read masters.
// Each granted read takes IDLE -> ACCESS -> RESP; readdata is registered before return.
module tag_nios_system_sysid_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_read,
  input  logic                  m0_address,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  input  logic                  m1_read,
  input  logic                  m1_address,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  s_address,
  input  logic [DATA_WIDTH-1:0] s_readdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e                state_q;
  logic                  win_q;
  logic                  last_q;
  logic                  addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic grant_valid;
  logic grant_sel;

  // On a tie the master that was not served last wins; otherwise the lone requester.
  always_comb begin
    grant_valid = m0_read | m1_read;
    grant_sel   = 1'b0;
    if (m0_read && m1_read) begin
      grant_sel = ~last_q;
    end else if (m1_read) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            win_q   <= grant_sel;
            addr_q  <= grant_sel ? m1_address : m0_address;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          rdata_q <= s_readdata;
          state_q <= StResp;
        end
        StResp: begin
          last_q  <= win_q;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A master that dropped read mid-transfer simply sees no acknowledge in RESP.
  assign m0_waitrequest = m0_read & ~((state_q == StResp) & ~win_q);
  assign m1_waitrequest = m1_read & ~((state_q == StResp) & win_q);

  assign m0_readdata = rdata_q;
  assign m1_readdata = rdata_q;
  assign s_address   = addr_q;

endmodule

// File: tb/tb_tag_nios_system_sysid_arbiter.sv
// Scoreboard bench for the sysid read arbiter: drivers push expected responses, a negedge
// monitor pops and compares on every acknowledge.
module tb_tag_nios_system_sysid_arbiter;

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] ID_WORD = 32'h606FAD3A;

  logic          clock;
  logic          reset;
  logic          m0_read;
  logic          m0_address;
  logic          m0_waitrequest;
  logic [DW-1:0] m0_readdata;
  logic          m1_read;
  logic          m1_address;
  logic          m1_waitrequest;
  logic [DW-1:0] m1_readdata;
  logic          s_address;
  logic [DW-1:0] s_readdata;

  tag_nios_system_sysid_arbiter #(
    .DATA_WIDTH(DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .m0_read       (m0_read),
    .m0_address    (m0_address),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata   (m0_readdata),
    .m1_read       (m1_read),
    .m1_address    (m1_address),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata   (m1_readdata),
    .s_address     (s_address),
    .s_readdata    (s_readdata)
  );

  function automatic logic [DW-1:0] mem(input logic a);
    return a ? ID_WORD : 32'h0000_0000;
  endfunction

  assign s_readdata = mem(s_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          addr;
    int            due_min;
    int            due_max;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;

  // Fairness tracking: if the other master was requesting in the IDLE cycle after an
  // acknowledge, the same master must not be acknowledged next.
  bit fair_en     = 1'b0;
  bit prev_valid  = 1'b0;
  int prev_m      = 0;
  int prev_cyc    = 0;
  bit pend_other  = 1'b0;

  task automatic ack(input int m, input logic [DW-1:0] d);
    exp_t e;
    checks++;
    if ((m == 0 && sb0.size() == 0) || (m == 1 && sb1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_ack m%0d cycle %0d got data %h required no ack", m, cyc, d);
      return;
    end
    if (m == 0) e = sb0.pop_front();
    else e = sb1.pop_front();
    if (d !== e.data) begin
      errors++;
      $display("FAIL ack_data m%0d got %h required %h", m, d, e.data);
    end
    checks++;
    if (cyc < e.due_min || cyc > e.due_max) begin
      errors++;
      $display("FAIL ack_cycle m%0d got %0d required %0d..%0d", m, cyc, e.due_min, e.due_max);
    end
    checks++;
    if (s_address !== e.addr) begin
      errors++;
      $display("FAIL s_address m%0d got %b required %b", m, s_address, e.addr);
    end
    if (fair_en && prev_valid) begin
      checks++;
      if (prev_m == m && pend_other) begin
        errors++;
        $display("FAIL fairness m%0d served twice got m%0d required m%0d", m, m, 1 - m);
      end
    end
    prev_valid = 1'b1;
    prev_m     = m;
    prev_cyc   = cyc;
    pend_other = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && cyc == prev_cyc + 1) pend_other = (prev_m == 0) ? m1_read : m0_read;
      if (m0_read && !m0_waitrequest) ack(0, m0_readdata);
      if (m1_read && !m1_waitrequest) ack(1, m1_readdata);
      if (!m0_read) begin
        checks++;
        if (m0_waitrequest !== 1'b0) begin
          errors++;
          $display("FAIL idle_wait m0 got %b required 0", m0_waitrequest);
        end
      end
      if (!m1_read) begin
        checks++;
        if (m1_waitrequest !== 1'b0) begin
          errors++;
          $display("FAIL idle_wait m1 got %b required 0", m1_waitrequest);
        end
      end
    end
  end

  task automatic set_req(input int m, input logic r, input logic a);
    if (m == 0) begin
      m0_read    = r;
      m0_address = a;
    end else begin
      m1_read    = r;
      m1_address = a;
    end
  endtask

  task automatic push_exp(input int m, input logic a, input int lo, input int hi);
    exp_t e;
    e.data    = mem(a);
    e.addr    = a;
    e.due_min = lo;
    e.due_max = hi;
    if (m == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic wait_ack(input int m);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (m == 0 && m0_read && !m0_waitrequest) return;
      if (m == 1 && m1_read && !m1_waitrequest) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout m%0d got no ack required ack within 20 cycles", m);
  endtask

  // Compliant master: holds read until acknowledged; lat < 0 means any legal latency (2..5).
  task automatic drive(input int m, input int n, input bit rnd, input logic a,
                       input int lat0, input int latn, input int gap_max);
    logic ad;
    int   lat;
    int   g;
    @(posedge clock);
    #1;
    for (int i = 0; i < n; i++) begin
      ad = rnd ? logic'($urandom_range(0, 1)) : a;
      set_req(m, 1'b1, ad);
      lat = (i == 0) ? lat0 : latn;
      if (lat < 0) push_exp(m, ad, cyc + 2, cyc + 5);
      else push_exp(m, ad, cyc + lat, cyc + lat);
      wait_ack(m);
      @(posedge clock);
      #1;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (i == n - 1 || g > 0) set_req(m, 1'b0, ad);
      repeat (g) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] got,
                            input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    m0_read    = 1'b1;
    m0_address = 1'b0;
    m1_read    = 1'b0;
    m1_address = 1'b0;
    @(negedge clock);
    check_bit("rst_s_address", s_address, 1'b0);
    check_word("rst_m0_readdata", m0_readdata, '0);
    check_word("rst_m1_readdata", m1_readdata, '0);
    check_bit("rst_m0_wait", m0_waitrequest, 1'b1);
    check_bit("rst_m1_wait", m1_waitrequest, 1'b0);
    m0_read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single m0 read of address 1.
    drive(0, 1, 1'b0, 1'b1, 2, 2, 0);

    // Tie from reset: m0 first, m1 three cycles later.
    do_reset();
    fork
      drive(0, 1, 1'b0, 1'b0, 2, 2, 0);
      drive(1, 1, 1'b0, 1'b1, 5, 5, 0);
    join

    // Continuous requests from both: strict alternation.
    fair_en = 1'b1;
    fork
      drive(0, 2, 1'b0, 1'b1, 2, 5, 0);
      drive(1, 2, 1'b0, 1'b0, 5, 5, 0);
    join

    // m1 back-to-back reads.
    drive(1, 3, 1'b0, 1'b1, 2, 2, 0);

    // Reset during ACCESS of an m0 read.
    @(posedge clock);
    #1;
    set_req(0, 1'b1, 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    check_bit("midrst_s_address", s_address, 1'b0);
    check_word("midrst_m0_readdata", m0_readdata, '0);
    check_bit("midrst_m0_wait", m0_waitrequest, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    push_exp(0, 1'b1, cyc + 2, cyc + 2);
    wait_ack(0);
    @(posedge clock);
    #1;
    set_req(0, 1'b0, 1'b1);

    // m0 wins the tie then abandons its read during ACCESS; m1 follows.
    do_reset();
    @(posedge clock);
    #1;
    set_req(0, 1'b1, 1'b0);
    set_req(1, 1'b1, 1'b1);
    push_exp(1, 1'b1, cyc + 5, cyc + 5);
    @(posedge clock);
    #1;
    set_req(0, 1'b0, 1'b0);
    wait_ack(1);
    @(posedge clock);
    #1;
    set_req(1, 1'b0, 1'b1);

    // Randomized traffic from both masters.
    do_reset();
    fork
      drive(0, 40, 1'b1, 1'b0, -1, -1, 3);
      drive(1, 40, 1'b1, 1'b0, -1, -1, 3);
    join

    repeat (4) @(posedge clock);
    n = sb0.size() + sb1.size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tag_nios_system_sysid_arbiter.md
# tag_nios_system_sysid_arbiter

Two-master read arbiter that shares the single system-ID control slave between the Nios II data master (m0) and the HPS lightweight bridge (m1). It accepts Avalon-MM reads with waitrequest from each master and grants them round-robin. It drives the slave's 1-bit address and registers the 32-bit readdata before returning it. It sits in the tag_nios_system interconnect directly in front of the sysid slave.

## Interface
- DATA_WIDTH, 32, readdata width on slave and master sides.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_read  in  1  master 0 read request; held until m0_waitrequest is low.
- m0_address  in  1  master 0 word address; held with m0_read.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_WIDTH  master 0 read data; valid only in the cycle m0_read=1 and m0_waitrequest=0.
- m1_read, m1_address, m1_waitrequest, m1_readdata: same as m0, for master 1.
- s_address  out  1  address to the sysid slave.
- s_readdata  in  DATA_WIDTH  combinational slave read data for s_address.

## Operation
- State machine with three states: IDLE, ACCESS, RESP.
- Registers:
  - state
  - win (1 bit, granted master)
  - last (1 bit, last master served)
  - addr_q (drives s_address)
  - rdata_q (drives both m*_readdata)
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master not equal to last.
  - On a grant: win <= winner, addr_q <= winner's address, go to ACCESS.
- ACCESS: rdata_q <= s_readdata (s_address = addr_q is stable this cycle); go to RESP.
- RESP: last <= win; go to IDLE.
- mX_waitrequest = mX_read & ~(state==RESP & win==X). This is combinational. The non-winner, and every master in any other state, is stalled.
- A master cannot be re-granted in the IDLE cycle that follows its own RESP unless the other master is idle.
- Protocol violation: the winner drops read during ACCESS or RESP. The sequence still completes and the data is discarded. No other state is affected.
- Reads only. There is no write path; the slave is read-only.

## Timing
- Reset values:
  - state = IDLE
  - win = 0
  - last = 1, so m0 wins the first tie
  - addr_q = 0, so s_address = 0
  - rdata_q = 0
  - m*_waitrequest = m*_read, i.e. stalled
- Latency: read asserted in cycle N (state IDLE) → waitrequest low in cycle N+2 with data valid → transfer accepted at the end of N+2.
- Throughput: one transfer per 3 cycles. Both masters requesting continuously get strictly alternating grants, so each master sees one transfer every 6 cycles.
- s_address changes only on the IDLE→ACCESS edge. It holds its last value while idle.
- m*_readdata changes only on the ACCESS→RESP edge. It holds between transfers.
- Reset asserted mid-transfer (ACCESS or RESP):
  - Everything returns to reset values immediately.
  - The in-flight transfer is not acknowledged, and its waitrequest stays high.
  - After reset release, the still-asserted read is re-arbitrated from IDLE.
- Simultaneous new requests arriving in the RESP cycle are not sampled until the following IDLE cycle.

## Test plan
- The bench slave model returns 0x00000000 at address 0 and 0x606FAD3A at address 1.
- m0 reads address 1 alone from reset → m0_waitrequest low exactly in cycle N+2, m0_readdata=0x606FAD3A; m1_waitrequest stays 0 (m1_read low).
- m0 (address 0) and m1 (address 1) request in the same cycle from reset → m0 served first with 0x00000000 at N+2, m1 served with 0x606FAD3A at N+5. Each waitrequest is low for exactly one cycle.
- Both masters hold read continuously for 12 cycles → grants alternate m0,m1,m0,m1. There are 4 acknowledges total, no master is served twice in a row, and s_address toggles per the granted address.
- m1 alone issues 3 back-to-back reads to address 1 → acknowledges at cycles N+2, N+5, N+8, all with 0x606FAD3A; last=1 throughout.
- Reset pulsed during ACCESS of an m0 read → no acknowledge for that read. After release, m0 is re-granted and acknowledged 2 cycles after IDLE with correct data. s_address=0 and m0_readdata=0 during reset.
- m0 drops read during ACCESS → no m0 acknowledge; the FSM returns to IDLE after RESP; a pending m1 read is served next with correct data.
